audio_in: RTL and testbench

- Receive-side counterpart of the DAC serial transmitter. Deserialises the codec ADC stream (adcdat) into 16-bit left/right PCM words.
- Framing: codec-supplied bclk and adcclk (LRC). Format is left-justified, MSB first.
- All logic runs in the clk_50m domain; bclk, adcclk and adcdat are sampled as asynchronous inputs.
- Completed stereo pairs go to the synth/loopback path through a valid/ready handshake, with overrun reporting.

---
 rtl/audio_pkg.sv | 22 ++
 rtl/audio_in_sync_edge.sv | 28 ++
 rtl/audio_in.sv | 187 ++++++++++++++++++
 tb/tb_audio_in.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio codec definitions used by the ADC receiver and the DAC transmitter.
package audio_pkg;

  localparam int unsigned CLOCK_REF    = 50_000_000;
  localparam int unsigned CLOCK_SAMPLE = 48_000;
  localparam int unsigned SAMPLE_WIDTH = 16;

  // adcclk/daclrc level that denotes the left channel.
  localparam logic LEFT_LEVEL_DEF = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } lr_state_e;

  function automatic logic is_left(input logic lrc, input logic left_level);
    return lrc == left_level;
  endfunction

endpackage

// File: rtl/audio_in_sync_edge.sv
// Three-flop synchroniser for an asynchronous level, with rise/fall/toggle strobes
// taken from the two oldest stages.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic toggle_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o  = sync_q[1];
  assign rise_o   = sync_q[1] & ~sync_q[2];
  assign fall_o   = ~sync_q[1] & sync_q[2];
  assign toggle_o = sync_q[1] ^ sync_q[2];

endmodule

// File: rtl/audio_in.sv
// Codec ADC receiver: deserialises adcdat into left/right PCM words framed by
// bclk/adcclk and hands completed stereo pairs out through valid/ready.
module audio_in
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_WIDTH,
  parameter logic        LEFT_LEVEL = LEFT_LEVEL_DEF,
  parameter int unsigned BIT_DELAY  = 0
) (
  input  logic                  clk_50m,
  input  logic                  rst_n,
  input  logic                  bclk,
  input  logic                  adcclk,
  input  logic                  adcdat,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SW = (BIT_DELAY > 1) ? $clog2(BIT_DELAY + 1) : 1;

  logic bclk_rise, lrc_edge, lrc_lvl, dat_lvl;
  logic unused_bclk_lvl, unused_bclk_fall, unused_bclk_tog;
  logic unused_lrc_rise, unused_lrc_fall;
  logic unused_dat_rise, unused_dat_fall, unused_dat_tog;

  sync_edge u_sync_bclk (
    .clk_i   (clk_50m),
    .rst_ni  (rst_n),
    .d_i     (bclk),
    .level_o (unused_bclk_lvl),
    .rise_o  (bclk_rise),
    .fall_o  (unused_bclk_fall),
    .toggle_o(unused_bclk_tog)
  );

  sync_edge u_sync_lrc (
    .clk_i   (clk_50m),
    .rst_ni  (rst_n),
    .d_i     (adcclk),
    .level_o (lrc_lvl),
    .rise_o  (unused_lrc_rise),
    .fall_o  (unused_lrc_fall),
    .toggle_o(lrc_edge)
  );

  sync_edge u_sync_dat (
    .clk_i   (clk_50m),
    .rst_ni  (rst_n),
    .d_i     (adcdat),
    .level_o (dat_lvl),
    .rise_o  (unused_dat_rise),
    .fall_o  (unused_dat_fall),
    .toggle_o(unused_dat_tog)
  );

  lr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [SW-1:0]         skip_q, skip_d;
  logic                  chan_q, chan_d;
  logic [1:0]            prime_q, prime_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                  have_left_q, have_left_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  ferr_q, ferr_d;

  logic                  armed, lrc_go, word_done;
  logic [DATA_WIDTH-1:0] word;

  // The synchronisers reset to 0, so a high adcclk at reset release looks like
  // an edge; IDLE ignores edges until the pipeline has filled.
  assign armed  = (prime_q == 2'd3);
  assign lrc_go = lrc_edge && ((state_q != ST_IDLE) || armed);
  assign word   = {shreg_q[DATA_WIDTH-2:0], dat_lvl};

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      skip_q      <= '0;
      chan_q      <= 1'b0;
      prime_q     <= '0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      skip_q      <= skip_d;
      chan_q      <= chan_d;
      prime_q     <= prime_d;
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    skip_d      = skip_q;
    chan_d      = chan_q;
    prime_d     = armed ? prime_q : prime_q + 2'd1;
    left_hold_d = left_hold_q;
    have_left_d = have_left_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = valid_q;
    overrun_d   = 1'b0;
    ferr_d      = 1'b0;
    word_done   = 1'b0;

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (lrc_go) begin
      if (state_q == ST_SHIFT) begin
        ferr_d      = 1'b1;
        have_left_d = 1'b0;
      end
      bitcnt_d = '0;
      skip_d   = '0;
      chan_d   = is_left(lrc_lvl, LEFT_LEVEL);
      state_d  = (BIT_DELAY > 0) ? ST_SKIP : ST_SHIFT;
    end else if (bclk_rise) begin
      case (state_q)
        ST_SKIP: begin
          if (skip_q == SW'(BIT_DELAY - 1)) begin
            skip_d  = '0;
            state_d = ST_SHIFT;
          end else begin
            skip_d = skip_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          shreg_d  = word;
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == CW'(DATA_WIDTH - 1)) begin
            word_done = 1'b1;
            state_d   = ST_HOLD;
          end
        end
        default: ;
      endcase
    end

    if (word_done) begin
      if (chan_q) begin
        left_hold_d = word;
        have_left_d = 1'b1;
      end else if (have_left_q) begin
        left_d      = left_hold_q;
        right_d     = word;
        valid_d     = 1'b1;
        overrun_d   = valid_q & ~sample_ready;
        have_left_d = 1'b0;
      end
    end
  end

  assign left_data    = left_q;
  assign right_data   = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_audio_in.sv
// Directed + randomised bench for audio_in: a codec-side serialiser drives both a
// left-justified and an I2S instance; expected pairs come from the words sent.
module tb_audio_in;

  localparam int DW = 16;
  localparam int HC = 8;  // clk_50m cycles per bclk phase

  logic clk_50m = 1'b0;
  logic rst_n, bclk, adcclk, adcdat, sample_ready, ready2;
  logic [DW-1:0] left_data, right_data, l2, r2;
  logic sample_valid, overrun, frame_err, v2, ov2, fe2;

  int n_assert = 0;
  int n_fail   = 0;
  int ov_cnt   = 0;
  int fe_cnt   = 0;
  logic pending;  // model: a pair is held and not yet accepted

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) begin
    if (overrun) ov_cnt++;
    if (frame_err) fe_cnt++;
  end

  audio_in #(.DATA_WIDTH(DW), .LEFT_LEVEL(1'b1), .BIT_DELAY(0)) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .bclk(bclk), .adcclk(adcclk), .adcdat(adcdat),
    .left_data(left_data), .right_data(right_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .frame_err(frame_err)
  );

  audio_in #(.DATA_WIDTH(DW), .LEFT_LEVEL(1'b1), .BIT_DELAY(1)) dut_i2s (
    .clk_50m(clk_50m), .rst_n(rst_n), .bclk(bclk), .adcclk(adcclk), .adcdat(adcdat),
    .left_data(l2), .right_data(r2), .sample_valid(v2),
    .sample_ready(ready2), .overrun(ov2), .frame_err(fe2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bclk slot: falling edge drives lrc/data, task returns at the rising edge.
  task automatic do_bit(input logic lrc, input logic d);
    repeat (HC) @(negedge clk_50m);
    bclk = 1'b0;
    adcclk = lrc;
    adcdat = d;
    repeat (HC) @(negedge clk_50m);
    bclk = 1'b1;
  endtask

  task automatic send_chan(input logic lrc, input logic [DW-1:0] w, input int lead,
                           input int nbits, input logic lead_bit);
    for (int i = 0; i < lead; i++) do_bit(lrc, lead_bit);
    for (int i = 0; i < nbits; i++) do_bit(lrc, w[DW-1-i]);
  endtask

  task automatic send_pad(input logic lrc, input int n);
    for (int i = 0; i < n; i++) do_bit(lrc, 1'b0);
  endtask

  // Called right after the final right-bit rising edge.
  task automatic expect_pair(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                             input logic raise_ready);
    logic exp_ov;
    exp_ov = pending & ~raise_ready;
    repeat (2) @(posedge clk_50m);
    #1;
    chk($sformatf("%s.valid_pre", tag), 32'(sample_valid), 32'(pending));
    chk($sformatf("%s.ovr_pre", tag), 32'(overrun), 32'd0);
    if (raise_ready) sample_ready = 1'b1;
    @(posedge clk_50m);
    #1;
    sample_ready = 1'b0;
    chk($sformatf("%s.valid", tag), 32'(sample_valid), 32'd1);
    chk($sformatf("%s.left", tag), 32'(left_data), 32'(l));
    chk($sformatf("%s.right", tag), 32'(right_data), 32'(r));
    chk($sformatf("%s.overrun", tag), 32'(overrun), 32'(exp_ov));
    pending = 1'b1;
    @(posedge clk_50m);
    #1;
    chk($sformatf("%s.ovr_post", tag), 32'(overrun), 32'd0);
    chk($sformatf("%s.valid_post", tag), 32'(sample_valid), 32'd1);
  endtask

  task automatic lj_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                          input logic raise_ready);
    send_chan(1'b1, l, 0, DW, 1'b0);
    send_pad(1'b1, 32 - DW);
    send_chan(1'b0, r, 0, DW, 1'b0);
    expect_pair(tag, l, r, raise_ready);
    send_pad(1'b0, 32 - DW);
  endtask

  task automatic accept(input string tag);
    @(negedge clk_50m);
    sample_ready = 1'b1;
    @(negedge clk_50m);
    sample_ready = 1'b0;
    chk($sformatf("%s.cleared", tag), 32'(sample_valid), 32'd0);
    pending = 1'b0;
  endtask

  task automatic i2s_frame(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_chan(1'b1, l, 1, DW, ~l[DW-1]);
    send_pad(1'b1, 31 - DW);
    send_chan(1'b0, r, 1, DW, ~r[DW-1]);
    repeat (2) @(posedge clk_50m);
    #1;
    chk($sformatf("%s.valid_pre", tag), 32'(v2), 32'd0);
    @(posedge clk_50m);
    #1;
    chk($sformatf("%s.valid", tag), 32'(v2), 32'd1);
    chk($sformatf("%s.left", tag), 32'(l2), 32'(l));
    chk($sformatf("%s.right", tag), 32'(r2), 32'(r));
    send_pad(1'b0, 31 - DW);
  endtask

  initial begin
    int ov0, fe0;
    logic [DW-1:0] rl, rr;
    rst_n = 1'b0;
    bclk = 1'b1;
    adcclk = 1'b0;
    adcdat = 1'b0;
    sample_ready = 1'b0;
    ready2 = 1'b1;
    pending = 1'b0;

    repeat (4) @(negedge clk_50m);
    chk("rst.left", 32'(left_data), 32'd0);
    chk("rst.right", 32'(right_data), 32'd0);
    chk("rst.valid", 32'(sample_valid), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    chk("rst.i2s_valid", 32'(v2), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50m);

    // 1: basic left-justified pair, then accept
    fe0 = fe_cnt;
    lj_frame("t1", 16'hA5C3, 16'h1234, 1'b0);
    chk("t1.no_ferr", 32'(fe_cnt - fe0), 32'd0);
    accept("t1");
    chk("t1.left_hold", 32'(left_data), 32'hA5C3);

    // 2: reset mid-left-word, partial frame must not produce a pair
    send_chan(1'b1, 16'hBEEF, 0, 5, 1'b0);
    @(negedge clk_50m);
    rst_n = 1'b0;
    pending = 1'b0;
    @(negedge clk_50m);
    chk("t2.rst_left", 32'(left_data), 32'd0);
    chk("t2.rst_valid", 32'(sample_valid), 32'd0);
    rst_n = 1'b1;
    send_pad(1'b1, 27);
    send_chan(1'b0, 16'h5A5A, 0, DW, 1'b0);
    send_pad(1'b0, 32 - DW);
    chk("t2.no_early_valid", 32'(sample_valid), 32'd0);
    lj_frame("t2", 16'h00FF, 16'hFF00, 1'b0);
    accept("t2");

    // 3: two frames without acceptance -> one overrun
    ov0 = ov_cnt;
    lj_frame("t3a", 16'h1111, 16'h2222, 1'b0);
    lj_frame("t3b", 16'h3333, 16'h4444, 1'b0);
    chk("t3.ovr_count", 32'(ov_cnt - ov0), 32'd1);

    // 4: ready raised in the completion cycle -> no overrun
    ov0 = ov_cnt;
    lj_frame("t4", 16'h5566, 16'h7788, 1'b1);
    chk("t4.ovr_count", 32'(ov_cnt - ov0), 32'd0);
    accept("t4");

    // 5: truncated left word -> frame_err, lone right dropped, then a clean frame
    fe0 = fe_cnt;
    send_chan(1'b1, 16'h9999, 0, 10, 1'b0);
    send_chan(1'b0, 16'hC3C3, 0, DW, 1'b0);
    send_pad(1'b0, 32 - DW);
    chk("t5.ferr_count", 32'(fe_cnt - fe0), 32'd1);
    chk("t5.dropped", 32'(sample_valid), 32'd0);
    lj_frame("t5", 16'h0F0F, 16'hF0F0, 1'b0);

    // randomised frames with random acceptance against the pending model
    for (int k = 0; k < 6; k++) begin
      rl = 16'($urandom);
      rr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) accept("rnd");
      lj_frame($sformatf("rnd%0d", k), rl, rr, ($urandom_range(0, 3) == 0));
    end
    accept("rnd_end");

    // 6: I2S instance, MSB on the second bclk rise after the adcclk edge
    i2s_frame("t6a", 16'h8001, 16'h7FFE);
    rl = 16'($urandom);
    rr = 16'($urandom);
    i2s_frame("t6b", rl, rr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
